// File: rtl/regfile_scoreboard_if.sv
// Decode-stage bundle between the pipeline control and the register file scoreboard.
//   master : decode/issue/write-back/squash side; drives requests and events, sees operands + stall
//   slave  : regfile_scoreboard; returns operand data, per-port busy and the stall decision
//   rd_valid/rd_addr/rd_data/rd_busy : NRD packed read ports (port i at [i*W +: W])
//   issue_*  : destination leaving decode; wb_* : write-back; squash_* : killed write
//   stall    : decode must hold this cycle
interface regfile_scoreboard_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned NRD  = 2
);
   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [NRD-1:0]      rd_valid;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                issue_en;
   logic [AW-1:0]       issue_rd;
   logic                wb_en;
   logic [AW-1:0]       wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                squash_en;
   logic [AW-1:0]       squash_rd;
   logic                stall;

   modport master (
      output rd_valid, rd_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data,
             squash_en, squash_rd,
      input  rd_data, rd_busy, stall
   );

   modport slave (
      input  rd_valid, rd_addr, issue_en, issue_rd, wb_en, wb_addr, wb_data,
             squash_en, squash_rd,
      output rd_data, rd_busy, stall
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports, write-first write-back bypass and
// a per-register pending-write counter that turns RAW hazards into a single stall.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; clears the array and every counter
//   bus  : regfile_scoreboard_if.slave (read ports, issue/write-back/squash events, stall)
// Interface parameters XLEN/NREG/NRD must match the module parameters.
module regfile_scoreboard #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned PEND_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_scoreboard_if.slave  bus
);
   localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned CW  = PEND_W + 1;
   localparam logic [PEND_W-1:0] PMAX = '1;

   logic [XLEN-1:0]   mem      [NREG];
   logic [PEND_W-1:0] pend     [NREG];
   logic [PEND_W-1:0] pend_nxt [NREG];

   logic [NRD*XLEN-1:0] rd_data_c;
   logic [NRD-1:0]      rd_busy_c;
   logic                sat_c;
   logic                stall_c;
   logic                issue_acc_c;

   // Operand read with write-first bypass; busy uses the effective count so a
   // same-cycle write-back of the last outstanding write releases the operand.
   always_comb begin
      logic [AW-1:0]     a;
      logic              hit;
      logic [PEND_W-1:0] p;
      rd_data_c = '0;
      rd_busy_c = '0;
      a         = '0;
      hit       = 1'b0;
      p         = '0;
      for (int i = 0; i < int'(NRD); i++) begin
         a   = bus.rd_addr[i*AW +: AW];
         hit = bus.wb_en && (bus.wb_addr == a);
         p   = pend[a];
         if (a != '0) begin
            rd_data_c[i*XLEN +: XLEN] = hit ? bus.wb_data : mem[a];
            rd_busy_c[i] = bus.rd_valid[i] &&
                           ((p > PEND_W'(1)) || ((p == PEND_W'(1)) && !hit));
         end
      end
   end

   // Stall: any busy operand, or an issue to a saturated counter that no write-back frees.
   always_comb begin
      sat_c = bus.issue_en && (bus.issue_rd != '0) && (pend[bus.issue_rd] == PMAX) &&
              !(bus.wb_en && (bus.wb_addr == bus.issue_rd));
      stall_c     = (|rd_busy_c) || sat_c;
      issue_acc_c = bus.issue_en && !stall_c;
   end

   assign bus.rd_data = rd_data_c;
   assign bus.rd_busy = rd_busy_c;
   assign bus.stall   = stall_c;

   // Net counter update; both decrements are gated on the pre-edge count and the
   // result clamps at zero when write-back and squash hit a count of one together.
   always_comb begin
      logic          inc;
      logic          dw;
      logic          ds;
      logic [CW-1:0] up;
      logic [CW-1:0] dn;
      inc = 1'b0;
      dw  = 1'b0;
      ds  = 1'b0;
      up  = '0;
      dn  = '0;
      pend_nxt[0] = '0;
      for (int r = 1; r < int'(NREG); r++) begin
         inc = issue_acc_c && (bus.issue_rd == AW'(r));
         dw  = bus.wb_en && (bus.wb_addr == AW'(r)) && (pend[r] != '0);
         ds  = bus.squash_en && (bus.squash_rd == AW'(r)) && (pend[r] != '0);
         up  = CW'(pend[r]) + CW'(inc);
         dn  = CW'(dw) + CW'(ds);
         pend_nxt[r] = (up > dn) ? PEND_W'(up - dn) : '0;
      end
   end

   // Array and counter state; register 0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < int'(NREG); r++) begin
            mem[r]  <= '0;
            pend[r] <= '0;
         end
      end else begin
         for (int r = 0; r < int'(NREG); r++) begin
            pend[r] <= pend_nxt[r];
         end
         if (bus.wb_en && (bus.wb_addr != '0)) begin
            mem[bus.wb_addr] <= bus.wb_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue, and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;

   typedef struct {
      string       name;
      logic [63:0] data;
      logic [1:0]  busy;
      logic        stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   done  = 1'b0;

   regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

   regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PEND_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge and return all inputs to idle.
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.rd_valid  = '0;
      bus.rd_addr   = '0;
      bus.issue_en  = 1'b0;
      bus.issue_rd  = '0;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      bus.squash_en = 1'b0;
      bus.squash_rd = '0;
   endtask

   task automatic rd(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
      bus.rd_valid = v;
      bus.rd_addr  = {a1, a0};
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.wb_en   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
   endtask

   task automatic iss(input logic [4:0] a);
      bus.issue_en = 1'b1;
      bus.issue_rd = a;
   endtask

   task automatic sq(input logic [4:0] a);
      bus.squash_en = 1'b1;
      bus.squash_rd = a;
   endtask

   task automatic expect_out(input string name, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] busy, input logic stall);
      exp_t e;
      e.name  = name;
      e.data  = {d1, d0};
      e.busy  = busy;
      e.stall = stall;
      q.push_back(e);
   endtask

   // Monitor: compares every pending expectation half a cycle after it was issued.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         n_vec++;
         if (bus.rd_data !== e.data) begin
            n_bad++;
            $display("FAIL %s: got data=%h, want data=%h", e.name, bus.rd_data, e.data);
         end
         if (bus.rd_busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s: got busy=%b, want busy=%b", e.name, bus.rd_busy, e.busy);
         end
         if (bus.stall !== e.stall) begin
            n_bad++;
            $display("FAIL %s: got stall=%b, want stall=%b", e.name, bus.stall, e.stall);
         end
      end
      if (done) begin
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
         $finish;
      end
   end

   initial begin
      bus.rd_valid  = '0;
      bus.rd_addr   = '0;
      bus.issue_en  = 1'b0;
      bus.issue_rd  = '0;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      bus.squash_en = 1'b0;
      bus.squash_rd = '0;

      // reset then read
      cyc(); rd(2'b11, 5'd5, 5'd0); expect_out("in_reset", 0, 0, 2'b00, 0);
      cyc(); rst = 1'b0; rd(2'b11, 5'd5, 5'd0); expect_out("after_reset", 0, 0, 2'b00, 0);

      // bypass and write visibility
      cyc(); rd(2'b10, 5'd5, 5'd7); wb(5'd7, 32'hDEADBEEF);
      expect_out("bypass", 0, 32'hDEADBEEF, 2'b00, 0);
      cyc(); rd(2'b10, 5'd5, 5'd7); expect_out("array_after_wb", 0, 32'hDEADBEEF, 2'b00, 0);
      cyc(); rd(2'b11, 5'd0, 5'd0); wb(5'd0, 32'h1234); expect_out("x0_bypass", 0, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd0, 5'd7); expect_out("x0_array", 0, 32'hDEADBEEF, 2'b00, 0);

      // RAW stall on x3
      cyc(); iss(5'd3); rd(2'b01, 5'd3, 5'd0); expect_out("raw_issue", 0, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd3, 5'd0); expect_out("raw_busy", 0, 0, 2'b01, 1);
      cyc(); rd(2'b01, 5'd3, 5'd0); wb(5'd3, 32'h55); expect_out("raw_wb_release", 32'h55, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd3, 5'd0); expect_out("raw_after", 32'h55, 0, 2'b00, 0);

      // WAW / saturation on x4
      cyc(); iss(5'd4); expect_out("sat_iss1", 0, 0, 2'b00, 0);
      cyc(); iss(5'd4); expect_out("sat_iss2", 0, 0, 2'b00, 0);
      cyc(); iss(5'd4); expect_out("sat_iss3", 0, 0, 2'b00, 0);
      cyc(); iss(5'd4); expect_out("sat_iss4_stall", 0, 0, 2'b00, 1);
      cyc(); iss(5'd4); wb(5'd4, 32'hA1); rd(2'b00, 5'd4, 5'd0);
      expect_out("sat_iss_with_wb", 32'hA1, 0, 2'b00, 0);
      cyc(); wb(5'd4, 32'hA2); rd(2'b10, 5'd0, 5'd4); expect_out("waw_wb1", 0, 32'hA2, 2'b10, 1);
      cyc(); wb(5'd4, 32'hA3); rd(2'b10, 5'd0, 5'd4); expect_out("waw_wb2", 0, 32'hA3, 2'b10, 1);
      cyc(); wb(5'd4, 32'hA4); rd(2'b10, 5'd0, 5'd4); expect_out("waw_wb3", 0, 32'hA4, 2'b00, 0);
      cyc(); rd(2'b10, 5'd0, 5'd4); expect_out("waw_done", 0, 32'hA4, 2'b00, 0);

      // squash and simultaneity on x9 / x10
      cyc(); iss(5'd9); expect_out("sq_iss", 0, 0, 2'b00, 0);
      cyc(); iss(5'd9); sq(5'd9); expect_out("sq_with_iss", 0, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd9, 5'd0); expect_out("sq_still_one", 0, 0, 2'b01, 1);
      cyc(); sq(5'd10); rd(2'b01, 5'd10, 5'd0); expect_out("sq_idle_reg", 0, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd10, 5'd0); expect_out("sq_idle_after", 0, 0, 2'b00, 0);
      cyc(); wb(5'd9, 32'h99); sq(5'd9); rd(2'b10, 5'd0, 5'd9);
      expect_out("wb_sq_same", 0, 32'h99, 2'b00, 0);
      cyc(); rd(2'b10, 5'd0, 5'd9); expect_out("no_underflow", 0, 32'h99, 2'b00, 0);

      // async reset mid-flight with pend[3]=2
      cyc(); iss(5'd3); expect_out("rst_iss1", 0, 0, 2'b00, 0);
      cyc(); iss(5'd3); expect_out("rst_iss2", 0, 0, 2'b00, 0);
      cyc(); rd(2'b01, 5'd3, 5'd7); expect_out("rst_pre", 32'h55, 32'hDEADBEEF, 2'b01, 1);
      cyc(); rst = 1'b1; rd(2'b11, 5'd3, 5'd7); expect_out("rst_pulse", 0, 0, 2'b00, 0);
      @(negedge clk); #2; rst = 1'b0;
      cyc(); wb(5'd3, 32'h77); rd(2'b01, 5'd3, 5'd0); expect_out("late_wb", 32'h77, 0, 2'b00, 0);
      cyc(); rd(2'b11, 5'd3, 5'd7); expect_out("late_wb_after", 32'h77, 0, 2'b00, 0);

      cyc();
      done = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_timeout: summary not reached, %0d expectations pending", q.size());
      $fatal(1);
   end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with N read ports, same-cycle write-back bypass and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined core and replaces the fixed two-port register file plus ad-hoc forwarding-enable writes. Decode gets operand data and a single `stall` decision from one block. Issue, write-back and squash events update per-register pending counters, so RAW hazards on in-flight results are detected without comparing pipeline-stage addresses.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `NREG`, 32, number of architectural registers; register 0 is hardwired to zero. `AW = $clog2(NREG)`.
- `NRD`, 2, number of read ports (1..4).
- `PEND_W`, 2, width of each pending-write counter; max in-flight writes per register = `2**PEND_W - 1`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_valid`  in  NRD  port i is requesting operand i.
- `rd_addr`  in  NRD*AW  packed read addresses; port i at `[i*AW +: AW]`.
- `rd_data`  out  NRD*XLEN  packed read data, combinational.
- `rd_busy`  out  NRD  port i operand still has an outstanding write.
- `issue_en`  in  1  instruction with a destination is leaving decode.
- `issue_rd`  in  AW  destination of the issuing instruction.
- `wb_en`  in  1  write-back strobe.
- `wb_addr`  in  AW  write-back destination.
- `wb_data`  in  XLEN  write-back data.
- `squash_en`  in  1  a previously issued write was killed and will never write back.
- `squash_rd`  in  AW  destination of the killed write.
- `stall`  out  1  decode must hold; an issue presented this cycle is not accepted.

## Operation
- Storage: `NREG-1` registers of XLEN bits. Register 0 reads 0 and ignores writes, issues and squashes; its counter is always 0.
- Read data per port i:
  - `rd_addr==0` returns 0.
  - Otherwise, if `wb_en && wb_addr==rd_addr`, returns `wb_data` (write-first bypass).
  - Otherwise returns the array value.
- Pending counter `pend[r]` update each edge, for r ≠ 0:
  - Add 1 if an accepted issue targets r. An issue is accepted when `issue_en && !stall`.
  - Subtract 1 if `wb_en && wb_addr==r && pend[r]!=0`.
  - Subtract 1 if `squash_en && squash_rd==r && pend[r]!=0`.
  - All three may hit the same r in one cycle; apply the net sum. The two decrements never take the counter below 0.
- Effective pending `eff[r]` = `pend[r]`, minus 1 if a same-cycle write-back to r applies.
- `rd_busy[i]` = `rd_valid[i] && rd_addr[i]!=0 && eff[rd_addr[i]] != 0`.
- A write-back to a register with `pend==0` still writes data; this covers untracked writers and is not an error.
- `stall` = (OR of `rd_busy`) OR (`issue_en && issue_rd!=0 && pend[issue_rd]==max && !(wb_en && wb_addr==issue_rd)`).
  - A saturated counter blocks further issue to that register.
  - Stall is the only backpressure. Upstream must keep `issue_en`/`issue_rd` stable while stalled.
- WAW handling: each write-back clears one count. The operand remains busy until the youngest in-flight write retires.

## Timing
- Reset, asynchronous: all registers are 0 and all `pend` are 0. Outputs during and immediately after reset: `rd_data`=0, `rd_busy`=0, `stall`=0 (given the input combination).
- Reads and hazard outputs are purely combinational from current inputs and state: 0-cycle latency.
- A write becomes visible from the array on the cycle after `wb_en`. On the same cycle it is visible through the bypass.
- Counter changes are visible on the cycle after the event.
  - An issue at cycle t makes dependent reads busy from t+1.
  - A write-back at cycle t clears busy in t itself via `eff`.
- Reset asserted mid-operation clears all counters. In-flight write-backs arriving after reset still write data, with no counter underflow.
- No combinational path from `rd_data` back to `stall`. The `stall` path is address compares plus counter zero/max checks only.

## Test plan
- Reset then read: assert `rst`, release. Read ports 0/1 at addresses 5 and 0 with valid → `rd_data` 0/0, `rd_busy`=00, `stall`=0.
- Bypass: `wb_en`, addr 7, data 0xDEADBEEF while port 1 reads 7 → port 1 shows 0xDEADBEEF that cycle. Next cycle with `wb_en`=0 → still 0xDEADBEEF. A write to x0 of 0x1234 → x0 reads 0.
- RAW stall: issue rd=3 at t. At t+1 port 0 reads 3 → `rd_busy[0]`=1, `stall`=1. At t+2 `wb_en` addr 3, data 0x55 → same cycle `stall`=0, `rd_data`=0x55.
- WAW/saturation (PEND_W=2): issue rd=4 three times. A fourth issue to 4 → `stall`=1 and the counter stays 3. A write-back to 4 in the same cycle as the fourth issue → accepted, counter stays 3. Three more write-backs → reads of 4 not busy.
- Squash and simultaneity: issue rd=9, then squash 9 together with a new issue 9 → counter stays 1. Squash to a register with `pend`=0 → no change. Write-back + squash to 9 with `pend`=1 → counter 0, no underflow.
- Async reset mid-flight: with `pend[3]`=2, pulse `rst` between edges → `rd_busy` drops immediately, array reads 0. A later write-back to 3 writes data and the counter stays 0.
